// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_skew_feeder
//  Description : Upstream feeder for an N x N FP8 (E4M3) systolic PE array.
//                Accepts one K-step per beat (an A column vector and a B row
//                vector) over a valid/ready handshake. It drives the left-edge
//                (A) and top-edge (B) lanes with a diagonal skew: lane i lags
//                lane 0 by i cycles.
//                Each tile is sequenced as a one-cycle accumulator clear, then
//                K data beats, then a zero flush of 2N-1 cycles, then a single
//                done pulse that marks the PE outputs as final.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          clock
//    rst          synchronous active-high reset (aborts any tile in flight)
//    start_i      begin a tile; sampled only while idle
//    k_len_i      number of K beats in the tile; latched on start
//    in_valid_i   a_vec_i / b_vec_i hold a valid beat
//    in_ready_o   a beat is accepted this cycle if in_valid_i is also high
//    a_vec_i      A elements; element i at [8i+7:8i]
//    b_vec_i      B elements; same packing
//    a_lane_o     skewed A lanes to PE row i; lane i at [8i+7:8i]
//    b_lane_o     skewed B lanes to PE column j; same packing
//    clear_o      broadcast accumulator clear (first STREAM cycle only)
//    busy_o       high whenever a tile is in progress (any non-idle state)
//    done_o       one-cycle pulse: every PE output is final
// ============================================================================
module systolic_skew_feeder #(
    parameter int N   = 4,
    parameter int K_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [K_W-1:0]   k_len_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N*8-1:0]   a_vec_i,
    input  logic [N*8-1:0]   b_vec_i,
    output logic [N*8-1:0]   a_lane_o,
    output logic [N*8-1:0]   b_lane_o,
    output logic             clear_o,
    output logic             busy_o,
    output logic             done_o
);

    // Flush lasts 2N-1 cycles: long enough for the last element on lane N-1
    // to walk its own N-deep skew register and then N-1 PEs across the array.
    localparam int              FL_W       = (2 * N > 2) ? $clog2(2 * N) : 1;
    localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(2 * N - 2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q;
    logic [K_W-1:0]    k_len_q;
    logic [K_W-1:0]    beat_cnt_q;
    logic [FL_W-1:0]   flush_cnt_q;
    logic              clear_q;
    logic              in_ready_q;
    logic              busy_q;
    logic              done_q;

    logic              accept;
    logic              last_beat;
    logic [N*8-1:0]    a_stage0_d;
    logic [N*8-1:0]    b_stage0_d;

    // in_ready is a register, so the accept decision never depends
    // combinationally on anything but in_valid_i.
    assign accept    = in_valid_i & in_ready_q;

    // The beat counter only ever reaches k_len_q; it cannot wrap.
    assign last_beat = accept && ((beat_cnt_q + K_W'(1)) == k_len_q);

    // Bubble injection: a zero byte decodes to a zero product in the PE, so
    // cycles without an accepted beat leave the accumulators untouched.
    assign a_stage0_d = accept ? a_vec_i : '0;
    assign b_stage0_d = accept ? b_vec_i : '0;

    // ------------------------------------------------------------------------
    // Tile sequencer with registered control outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
            clear_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // clear and done are single-cycle pulses by construction
            clear_q <= 1'b0;
            done_q  <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // A zero-length tile would clear the array and report done
                    // with nothing computed, so it is not started at all.
                    if (start_i && (k_len_i != '0)) begin
                        state_q    <= S_STREAM;
                        k_len_q    <= k_len_i;
                        beat_cnt_q <= '0;
                        clear_q    <= 1'b1;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end

                S_STREAM: begin
                    if (accept) begin
                        beat_cnt_q <= beat_cnt_q + K_W'(1);
                    end
                    if (last_beat) begin
                        state_q     <= S_FLUSH;
                        in_ready_q  <= 1'b0;
                        flush_cnt_q <= '0;
                    end
                end

                S_FLUSH: begin
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + FL_W'(1);
                    end
                end

                S_DONE: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    beat_cnt_q  <= '0;
                    flush_cnt_q <= '0;
                end

                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    beat_cnt_q  <= '0;
                    flush_cnt_q <= '0;
                end
            endcase
        end
    end

    assign clear_o    = clear_q;
    assign in_ready_o = in_ready_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

    // ------------------------------------------------------------------------
    // Skew datapath: lane i is an (i+1)-deep byte shift register. Stage 0
    // captures the accepted element (or a zero bubble); the last stage drives
    // the lane output. The registers shift every cycle regardless of state,
    // which is what drains them during FLUSH.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [7:0] a_sr_q [0:gi];
        logic [7:0] b_sr_q [0:gi];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= gi; k++) begin
                    a_sr_q[k] <= 8'h00;
                    b_sr_q[k] <= 8'h00;
                end
            end else begin
                a_sr_q[0] <= a_stage0_d[8*gi +: 8];
                b_sr_q[0] <= b_stage0_d[8*gi +: 8];
                for (int k = 1; k <= gi; k++) begin
                    a_sr_q[k] <= a_sr_q[k-1];
                    b_sr_q[k] <= b_sr_q[k-1];
                end
            end
        end

        assign a_lane_o[8*gi +: 8] = a_sr_q[gi];
        assign b_lane_o[8*gi +: 8] = b_sr_q[gi];
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_skew_feeder
//  Description : Directed self-checking bench for systolic_skew_feeder (N=4).
//                A behavioural N x N FP8 PE-array model consumes the skewed
//                lanes. At each done pulse its results are compared with a
//                golden matmul of the beats that were driven.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_skew_feeder;

    localparam int N   = 4;
    localparam int K_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [K_W-1:0]   k_len;
    logic             in_valid;
    logic [N*8-1:0]   a_vec;
    logic [N*8-1:0]   b_vec;
    logic             in_ready;
    logic [N*8-1:0]   a_lane;
    logic [N*8-1:0]   b_lane;
    logic             clear;
    logic             busy;
    logic             done;

    systolic_skew_feeder #(.N(N), .K_W(K_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .k_len_i    (k_len),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .a_vec_i    (a_vec),
        .b_vec_i    (b_vec),
        .a_lane_o   (a_lane),
        .b_lane_o   (b_lane),
        .clear_o    (clear),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    // Lane history for the PE-array model, indexed by cycle number.
    logic [N*8-1:0] ha [0:2047];
    logic [N*8-1:0] hb [0:2047];
    int             clr_cyc = 0;

    always @(negedge clk) begin
        if (cyc < 2048) begin
            ha[cyc] <= a_lane;
            hb[cyc] <= b_lane;
        end
        if (clear) clr_cyc <= cyc;
    end

    // Beats of the tile under test, for the golden matmul.
    logic [N*8-1:0] ga [0:15];
    logic [N*8-1:0] gb [0:15];
    int             gk = 0;

    function automatic real fp8(input logic [7:0] x);
        int  e;
        int  m;
        real v;
        real s;
        e = int'(x[6:3]);
        m = int'(x[2:0]);
        if (e == 0) begin
            v = m / 8.0;
            e = 1;
        end else begin
            v = 1.0 + m / 8.0;
        end
        s = 1.0;
        if (e > 7) repeat (e - 7) s = s * 2.0;
        else       repeat (7 - e) s = s / 2.0;
        v = v * s;
        if (x[7]) v = -v;
        return v;
    endfunction

    function automatic logic [15:0] to_bf16(input real x);
        logic [63:0] bits;
        int          e8;
        bits = $realtobits(x);
        if (x == 0.0) return 16'h0000;
        e8 = int'(bits[62:52]) - 1023 + 127;
        return {bits[63], e8[7:0], bits[51:45]};
    endfunction

    // PE(i,j) sees lane i delayed j more cycles and lane j delayed i more.
    function automatic real pe_model(input int i, input int j, input int donec);
        real s;
        int  ta;
        int  tb;
        s = 0.0;
        for (int t = clr_cyc; t < donec; t++) begin
            ta = t - j;
            tb = t - i;
            if (ta >= clr_cyc && tb >= clr_cyc)
                s = s + fp8(ha[ta][8*i +: 8]) * fp8(hb[tb][8*j +: 8]);
        end
        return s;
    endfunction

    function automatic real golden(input int i, input int j);
        real s;
        s = 0.0;
        for (int k = 0; k < gk; k++)
            s = s + fp8(ga[k][8*i +: 8]) * fp8(gb[k][8*j +: 8]);
        return s;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        start    = 1'b0;
        k_len    = '0;
        in_valid = 1'b0;
        a_vec    = '0;
        b_vec    = '0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset;
        rst = 1'b1; start = 1'b1; k_len = 8'd4; in_valid = 1'b1;
        a_vec = 32'h11223344; b_vec = 32'h55667788;
        repeat (3) begin
            tick;
            n_total++;
            if ({a_lane, b_lane, clear, in_ready, busy, done} !== '0)
                $display("FAIL reset_outputs: got a=%h b=%h c/r/b/d=%b%b%b%b expected all 0",
                         a_lane, b_lane, clear, in_ready, busy, done);
            else n_pass++;
        end
        rst = 1'b0;
        idle_inputs();
        repeat (2) begin
            tick;
            n_total++;
            if ({a_lane, b_lane, clear, in_ready, busy, done} !== '0)
                $display("FAIL idle_after_reset: got a=%h b=%h c/r/b/d=%b%b%b%b expected all 0",
                         a_lane, b_lane, clear, in_ready, busy, done);
            else n_pass++;
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_single_beat;
        logic [31:0] va;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [3:0]  ectl;
        real         c;
        va = 32'h50484038;
        start = 1'b1; k_len = 8'd1; in_valid = 1'b1;
        a_vec = va; b_vec = 32'h38383838;
        ga[0] = va; gb[0] = 32'h38383838; gk = 1;
        for (int n = 1; n <= 11; n++) begin
            tick;
            start = 1'b0;
            if (n == 2) begin
                // still valid but not ready: must not reach any lane
                a_vec = 32'hA5A5A5A5;
                b_vec = 32'h5A5A5A5A;
            end
            for (int i = 0; i < N; i++) begin
                ea[8*i +: 8] = (n == 2 + i) ? va[8*i +: 8] : 8'h00;
                eb[8*i +: 8] = (n == 2 + i) ? 8'h38 : 8'h00;
            end
            ectl = {n == 1, n == 1, n >= 1 && n <= 9, n == 9};
            n_total++;
            if ({clear, in_ready, busy, done} !== ectl)
                $display("FAIL single_ctl n=%0d: got c/r/b/d=%b expected %b", n,
                         {clear, in_ready, busy, done}, ectl);
            else n_pass++;
            n_total++;
            if (a_lane !== ea || b_lane !== eb)
                $display("FAIL single_lanes n=%0d: got a=%h b=%h expected a=%h b=%h",
                         n, a_lane, b_lane, ea, eb);
            else n_pass++;
            if (n == 9) begin
                c = pe_model(0, 0, cyc);
                n_total++;
                if (to_bf16(c) !== 16'h3F80)
                    $display("FAIL single_pe00_bf16: got %h expected 3f80", to_bf16(c));
                else n_pass++;
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        n_total++;
                        if (pe_model(i, j, cyc) != golden(i, j))
                            $display("FAIL single_pe(%0d,%0d): got %f expected %f", i, j,
                                     pe_model(i, j, cyc), golden(i, j));
                        else n_pass++;
                    end
            end
        end
        idle_inputs();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_stall_bubbles;
        logic [31:0] sa [0:2];
        logic [31:0] sb [0:2];
        int          acc_at [0:15];
        logic [31:0] ea;
        logic [31:0] eb;
        logic [3:0]  ectl;
        int          m;
        sa[0] = 32'h40383C30; sa[1] = 32'h38B84044; sa[2] = 32'h3C3C3838;
        sb[0] = 32'h38403038; sb[1] = 32'h30383C40; sb[2] = 32'hB8383840;
        for (int k = 0; k < 16; k++) acc_at[k] = -1;
        acc_at[1] = 0; acc_at[3] = 1; acc_at[4] = 2;   // valid pattern 1,0,1,1
        for (int k = 0; k < 3; k++) begin ga[k] = sa[k]; gb[k] = sb[k]; end
        gk = 3;
        start = 1'b1; k_len = 8'd3; in_valid = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            tick;
            start = 1'b0;
            case (n)
                1:       begin in_valid = 1'b1; a_vec = sa[0]; b_vec = sb[0]; end
                2:       begin in_valid = 1'b0; a_vec = 32'h7E7E7E7E; b_vec = 32'h7E7E7E7E; end
                3:       begin in_valid = 1'b1; a_vec = sa[1]; b_vec = sb[1]; end
                4:       begin in_valid = 1'b1; a_vec = sa[2]; b_vec = sb[2]; end
                default: begin in_valid = 1'b1; a_vec = 32'h7E7E7E7E; b_vec = 32'h7E7E7E7E; end
            endcase
            for (int i = 0; i < N; i++) begin
                m = n - 1 - i;
                ea[8*i +: 8] = (m >= 1 && acc_at[m] >= 0) ? sa[acc_at[m]][8*i +: 8] : 8'h00;
                eb[8*i +: 8] = (m >= 1 && acc_at[m] >= 0) ? sb[acc_at[m]][8*i +: 8] : 8'h00;
            end
            ectl = {n == 1, n >= 1 && n <= 4, n >= 1 && n <= 12, n == 12};
            n_total++;
            if ({clear, in_ready, busy, done} !== ectl)
                $display("FAIL stall_ctl n=%0d: got c/r/b/d=%b expected %b", n,
                         {clear, in_ready, busy, done}, ectl);
            else n_pass++;
            n_total++;
            if (a_lane !== ea || b_lane !== eb)
                $display("FAIL stall_lanes n=%0d: got a=%h b=%h expected a=%h b=%h",
                         n, a_lane, b_lane, ea, eb);
            else n_pass++;
            if (n == 12)
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        n_total++;
                        if (pe_model(i, j, cyc) != golden(i, j))
                            $display("FAIL stall_pe(%0d,%0d): got %f expected %f", i, j,
                                     pe_model(i, j, cyc), golden(i, j));
                        else n_pass++;
                    end
        end
        idle_inputs();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_ignored_starts;
        int n_clear;
        int n_done;
        start = 1'b1; k_len = 8'd0;
        for (int n = 1; n <= 3; n++) begin
            tick;
            start = 1'b0;
            n_total++;
            if ({clear, in_ready, busy, done} !== 4'b0000)
                $display("FAIL ignore_klen0 n=%0d: got c/r/b/d=%b expected 0000", n,
                         {clear, in_ready, busy, done});
            else n_pass++;
        end
        n_clear = 0; n_done = 0;
        start = 1'b1; k_len = 8'd2; in_valid = 1'b0;
        a_vec = 32'h38383838; b_vec = 32'h38383838;
        for (int n = 1; n <= 20; n++) begin
            tick;
            if (clear) n_clear++;
            if (done)  n_done++;
            // stray starts with a different length during STREAM and FLUSH
            start    = (n == 2 || n == 5 || n == 9);
            k_len    = 8'd7;
            in_valid = (n == 3 || n == 4);
            n_total++;
            if (in_ready !== (n >= 1 && n <= 4))
                $display("FAIL ignore_ready n=%0d: got %b expected %b", n, in_ready,
                         (n >= 1 && n <= 4));
            else n_pass++;
            n_total++;
            if (done !== (n == 12))
                $display("FAIL ignore_done n=%0d: got %b expected %b", n, done, (n == 12));
            else n_pass++;
        end
        n_total++;
        if (n_clear != 1 || n_done != 1)
            $display("FAIL ignore_pulse_count: got clear=%0d done=%0d expected 1 and 1",
                     n_clear, n_done);
        else n_pass++;
        idle_inputs();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid_stream;
        logic [31:0] rb [0:4];
        int          n_done;
        rb[0] = 32'h38403C30; rb[1] = 32'h40383838; rb[2] = 32'hB83C4038;
        rb[3] = 32'h30303838; rb[4] = 32'h3C38B840;
        start = 1'b1; k_len = 8'd5; in_valid = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            tick;
            start    = 1'b0;
            in_valid = 1'b1;
            a_vec    = rb[n - 1];
            b_vec    = rb[4 - n];
            rst      = (n == 3);
        end
        tick;
        rst = 1'b0;
        in_valid = 1'b0;
        n_total++;
        if ({a_lane, b_lane, clear, in_ready, busy, done} !== '0)
            $display("FAIL midreset_outputs: got a=%h b=%h c/r/b/d=%b%b%b%b expected all 0",
                     a_lane, b_lane, clear, in_ready, busy, done);
        else n_pass++;
        n_done = 0;
        for (int n = 1; n <= 12; n++) begin
            tick;
            if (done || busy) n_done++;
        end
        n_total++;
        if (n_done != 0)
            $display("FAIL midreset_no_done: got %0d busy/done cycles expected 0", n_done);
        else n_pass++;
        // fresh tile with the full length
        for (int k = 0; k < 5; k++) begin ga[k] = rb[k]; gb[k] = rb[4 - k]; end
        gk = 5;
        start = 1'b1; k_len = 8'd5;
        for (int m = 1; m <= 15; m++) begin
            tick;
            start    = 1'b0;
            in_valid = 1'b1;
            a_vec    = (m <= 5) ? rb[m - 1] : 32'h7E7E7E7E;
            b_vec    = (m <= 5) ? rb[5 - m] : 32'h7E7E7E7E;
            n_total++;
            if ({clear, in_ready, done} !== {m == 1, m <= 5, m == 13})
                $display("FAIL midreset_tile m=%0d: got c/r/d=%b expected %b", m,
                         {clear, in_ready, done}, {m == 1, m <= 5, m == 13});
            else n_pass++;
            if (m == 13)
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        n_total++;
                        if (pe_model(i, j, cyc) != golden(i, j))
                            $display("FAIL midreset_pe(%0d,%0d): got %f expected %f", i, j,
                                     pe_model(i, j, cyc), golden(i, j));
                        else n_pass++;
                    end
        end
        idle_inputs();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back;
        logic [31:0] t1 [0:1];
        logic [31:0] t2a [0:3];
        logic [31:0] t2b [0:3];
        t1[0]  = 32'h44444444; t1[1]  = 32'hB8B8B8B8;
        t2a[0] = 32'h38403038; t2a[1] = 32'h3C38B840; t2a[2] = 32'h30383838; t2a[3] = 32'h4038443C;
        t2b[0] = 32'h40383830; t2b[1] = 32'h383CB838; t2b[2] = 32'h3838403C; t2b[3] = 32'hB0403838;
        ga[0] = t1[0]; ga[1] = t1[1]; gb[0] = t1[1]; gb[1] = t1[0]; gk = 2;
        start = 1'b1; k_len = 8'd2; in_valid = 1'b0;
        for (int n = 1; n <= 23; n++) begin
            tick;
            start    = (n == 11);
            k_len    = (n == 11) ? 8'd4 : 8'd2;
            in_valid = 1'b1;
            if (n <= 2)                 begin a_vec = t1[n - 1];   b_vec = t1[2 - n];   end
            else if (n >= 11 && n <= 15) begin
                a_vec = t2a[(n == 11) ? 0 : n - 12];
                b_vec = t2b[(n == 11) ? 0 : n - 12];
            end
            else                        begin a_vec = 32'h7E7E7E7E; b_vec = 32'h7E7E7E7E; end
            n_total++;
            if ({clear, done} !== {n == 1 || n == 12, n == 10 || n == 23})
                $display("FAIL b2b_ctl n=%0d: got c/d=%b expected %b", n, {clear, done},
                         {n == 1 || n == 12, n == 10 || n == 23});
            else n_pass++;
            if (n == 11) begin
                n_total++;
                if (busy !== 1'b0)
                    $display("FAIL b2b_idle_gap: got busy=%b expected 0", busy);
                else n_pass++;
            end
            if (n == 10 || n == 23) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        n_total++;
                        if (pe_model(i, j, cyc) != golden(i, j))
                            $display("FAIL b2b_pe(%0d,%0d) n=%0d: got %f expected %f", i, j, n,
                                     pe_model(i, j, cyc), golden(i, j));
                        else n_pass++;
                    end
                // load the second tile's golden after the first is checked
                for (int k = 0; k < 4; k++) begin ga[k] = t2a[k]; gb[k] = t2b[k]; end
                gk = 4;
            end
        end
        idle_inputs();
    endtask

    // ------------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_beat();
        test_stall_bubbles();
        test_ignored_starts();
        test_reset_mid_stream();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
